// File: rtl/missed_dose_pkg.sv
// missed_dose_pkg: shared FSM state, log entry layout and default sizes for the missed-dose logger
package missed_dose_pkg;
  typedef enum logic [1:0] {IDLE, WAIT, REQ} state_t;
  localparam int PILL_ID_W = 2;
  localparam int GRACE_SEC_DEF = 900;
  localparam int DEPTH_DEF = 8;
  localparam int TW_DEF = 24;
  typedef struct packed {
    logic [PILL_ID_W-1:0] pill_id;
    logic [TW_DEF-1:0]    ts;
  } entry_t;
endpackage

// File: rtl/dose_grace_timer.sv
// dose_grace_timer: per-pill due-edge detect, grace-window FSM/counter and expiry timestamp capture (req/alert/time out, grant in)
module dose_grace_timer
  import missed_dose_pkg::*;
#(
  parameter int GRACE_SEC = GRACE_SEC_DEF,
  parameter int TW = TW_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_tick,
  input  logic          i_due,
  input  logic          i_taken,
  input  logic [TW-1:0] i_time,
  input  logic          i_grant,
  output logic          o_req,
  output logic          o_alert,
  output logic [TW-1:0] o_time
);
  state_t        r_state;
  logic [11:0]   r_cnt;
  logic          r_due;
  logic          r_live;
  logic [TW-1:0] r_time;
  logic          w_edge;
  assign w_edge = i_due && !r_due && r_live;
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_due   <= 1'b0;
      r_live  <= 1'b0;
      r_time  <= '0;
    end else begin
      r_due  <= i_due;
      r_live <= 1'b1;
      case (r_state)
        IDLE: if (w_edge) begin
          r_state <= WAIT;
          r_cnt   <= '0;
        end
        WAIT: if (i_taken) r_state <= IDLE;
        else if (i_tick) begin
          if (r_cnt == 12'(GRACE_SEC - 1)) begin
            r_state <= REQ;
            r_time  <= i_time;
          end else r_cnt <= r_cnt + 1'b1;
        end
        REQ: if (i_grant) r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end
  assign o_req   = r_state == REQ;
  assign o_alert = r_state == WAIT;
  assign o_time  = r_time;
endmodule

// File: rtl/missed_dose_log.sv
// missed_dose_log: grace timers per pill, lowest-index push arbiter and overwrite-on-full FWFT log of {pill_id, time}
module missed_dose_log
  import missed_dose_pkg::*;
#(
  parameter int NUM_PILLS = 3,
  parameter int GRACE_SEC = GRACE_SEC_DEF,
  parameter int DEPTH = DEPTH_DEF,
  parameter int TW = TW_DEF,
  localparam int AW = $clog2(DEPTH),
  localparam int EW = PILL_ID_W + TW
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 tick_1s,
  input  logic [NUM_PILLS-1:0] pill_due,
  input  logic [NUM_PILLS-1:0] pill_taken,
  input  logic [TW-1:0]        time_bcd,
  input  logic                 rd_en,
  output logic [EW-1:0]        rd_data,
  output logic                 empty,
  output logic                 full,
  output logic [AW:0]          count,
  output logic                 overflow,
  output logic [NUM_PILLS-1:0] alert
);
  logic [NUM_PILLS-1:0] w_req;
  logic [NUM_PILLS-1:0] w_grant;
  logic [TW-1:0]        w_cap [NUM_PILLS];
  logic [PILL_ID_W-1:0] w_id;
  logic [EW-1:0]        w_entry;
  logic                 w_push;
  logic                 w_pop;
  logic [EW-1:0]        r_mem [DEPTH];
  logic [AW-1:0]        r_wp;
  logic [AW-1:0]        r_rp;
  logic [AW:0]          r_count;
  logic                 r_ovf;
  for (genvar p = 0; p < NUM_PILLS; p++) begin : g_pill
    dose_grace_timer #(.GRACE_SEC(GRACE_SEC), .TW(TW)) u_timer (
      .clk     (clk),
      .reset   (reset),
      .i_tick  (tick_1s),
      .i_due   (pill_due[p]),
      .i_taken (pill_taken[p]),
      .i_time  (time_bcd),
      .i_grant (w_grant[p]),
      .o_req   (w_req[p]),
      .o_alert (alert[p]),
      .o_time  (w_cap[p])
    );
  end
  always_comb begin
    w_id = '0;
    for (int k = NUM_PILLS - 1; k >= 0; k--) if (w_req[k]) w_id = PILL_ID_W'(k);
  end
  assign w_grant = w_req & (~w_req + 1'b1);
  assign w_push  = |w_req;
  assign w_entry = {w_id, w_cap[w_id]};
  assign w_pop   = rd_en && !empty;
  always_ff @(posedge clk) if (w_push) r_mem[r_wp] <= w_entry;
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wp    <= '0;
      r_rp    <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
    end else begin
      if (w_push) r_wp <= r_wp + 1'b1;
      if (w_pop || (w_push && full)) r_rp <= r_rp + 1'b1;
      if (w_push && full && !w_pop) r_ovf <= 1'b1;
      r_count <= (w_push && !w_pop && !full) ? r_count + 1'b1 :
                 (w_pop && !w_push) ? r_count - 1'b1 : r_count;
    end
  end
  assign count    = r_count;
  assign empty    = r_count == '0;
  assign full     = r_count == (AW + 1)'(DEPTH);
  assign overflow = r_ovf;
  assign rd_data  = empty ? '0 : r_mem[r_rp];
endmodule

// File: tb/tb_missed_dose_log.sv
// tb_missed_dose_log: directed and randomized checks of missed_dose_log against a queue-based reference model
module tb_missed_dose_log;
  localparam int G = 3;
  localparam int D = 4;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        tick_1s = 1'b0;
  logic        rd_en = 1'b0;
  logic [2:0]  pill_due = '0;
  logic [2:0]  pill_taken = '0;
  logic [23:0] time_bcd = '0;
  logic [25:0] rd_data;
  logic        empty, full, overflow;
  logic [2:0]  count, alert;
  int tests = 0;
  int fails = 0;
  logic [25:0] q[$];
  bit          m_win [3];
  bit          m_pend [3];
  int          m_ticks [3];
  logic [23:0] m_cap [3];
  logic [2:0]  m_prev;
  bit          m_ovf;
  always #5 clk = ~clk;
  missed_dose_log #(.NUM_PILLS(3), .GRACE_SEC(G), .DEPTH(D), .TW(24)) dut (
    .clk(clk), .reset(reset), .tick_1s(tick_1s), .pill_due(pill_due), .pill_taken(pill_taken),
    .time_bcd(time_bcd), .rd_en(rd_en), .rd_data(rd_data), .empty(empty), .full(full),
    .count(count), .overflow(overflow), .alert(alert)
  );
  task automatic model_reset();
    q.delete();
    for (int i = 0; i < 3; i++) begin
      m_win[i] = 0;
      m_pend[i] = 0;
      m_ticks[i] = 0;
      m_cap[i] = '0;
    end
    m_prev = 3'b111;
    m_ovf = 0;
  endtask
  task automatic model_step();
    int g = -1;
    for (int i = 0; i < 3; i++) if (m_pend[i] && g < 0) g = i;
    if (rd_en && q.size() > 0) void'(q.pop_front());
    if (g >= 0) begin
      if (q.size() == D) begin
        void'(q.pop_front());
        m_ovf = 1;
      end
      q.push_back({2'(g), m_cap[g]});
    end
    for (int i = 0; i < 3; i++) begin
      if (m_pend[i]) begin
        if (i == g) m_pend[i] = 0;
      end else if (m_win[i]) begin
        if (pill_taken[i]) m_win[i] = 0;
        else if (tick_1s) begin
          m_ticks[i]++;
          if (m_ticks[i] == G) begin
            m_win[i] = 0;
            m_pend[i] = 1;
            m_cap[i] = time_bcd;
          end
        end
      end else if (pill_due[i] && !m_prev[i]) begin
        m_win[i] = 1;
        m_ticks[i] = 0;
      end
    end
    m_prev = pill_due;
  endtask
  function automatic logic [34:0] exp_v();
    logic [2:0] a;
    for (int i = 0; i < 3; i++) a[i] = m_win[i];
    return {3'(q.size()), q.size() == 0, q.size() == D, m_ovf, a, (q.size() > 0) ? q[0] : 26'd0};
  endfunction
  function automatic logic [34:0] dut_v();
    return {count, empty, full, overflow, alert, rd_data};
  endfunction
  task automatic step(input logic [2:0] due, input logic [2:0] tk, input logic tick, input logic rd,
                      input logic [23:0] t);
    pill_due = due;
    pill_taken = tk;
    tick_1s = tick;
    rd_en = rd;
    time_bcd = t;
    model_step();
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
  endtask
  task automatic miss(input int p, input logic [23:0] t, input logic rd_at_grant);
    logic [2:0] d = 3'(1 << p);
    step(3'b000, 3'b000, 0, 0, 24'h0);
    step(d, 3'b000, 0, 0, 24'h0);
    step(d, 3'b000, 1, 0, 24'h0);
    step(d, 3'b000, 1, 0, 24'h0);
    step(d, 3'b000, 1, 0, t);
    step(d, 3'b000, 0, rd_at_grant, 24'h0);
  endtask
  task automatic test_reset();
    do_reset();
    tests++;
    if (dut_v() !== {3'd0, 1'b1, 1'b0, 1'b0, 3'd0, 26'd0}) begin
      fails++;
      $display("FAIL reset_values got=%h want=%h", dut_v(), {3'd0, 1'b1, 1'b0, 1'b0, 3'd0, 26'd0});
    end
  endtask
  task automatic test_missed();
    step(3'b000, 3'b000, 0, 0, 24'h0);
    step(3'b001, 3'b000, 0, 0, 24'h0);
    tests++;
    if (alert !== 3'b001) begin fails++; $display("FAIL missed_alert_rise got=%b want=001", alert); end
    step(3'b001, 3'b000, 1, 0, 24'h0);
    step(3'b001, 3'b000, 1, 0, 24'h0);
    tests++;
    if (dut_v() !== exp_v()) begin fails++; $display("FAIL missed_window got=%h want=%h", dut_v(), exp_v()); end
    step(3'b001, 3'b000, 1, 0, 24'h083015);
    tests++;
    if (alert !== 3'b000 || count !== 3'd0) begin
      fails++;
      $display("FAIL missed_expiry got alert=%b count=%0d want alert=000 count=0", alert, count);
    end
    step(3'b001, 3'b000, 0, 0, 24'h0);
    tests++;
    if (rd_data !== 26'h0083015 || count !== 3'd1 || empty !== 1'b0) begin
      fails++;
      $display("FAIL missed_logged got rd=%h count=%0d empty=%b want rd=0083015 count=1 empty=0", rd_data, count, empty);
    end
    step(3'b001, 3'b000, 0, 1, 24'h0);
    tests++;
    if (dut_v() !== exp_v()) begin fails++; $display("FAIL missed_pop got=%h want=%h", dut_v(), exp_v()); end
  endtask
  task automatic test_taken();
    step(3'b000, 3'b000, 0, 0, 24'h0);
    step(3'b010, 3'b000, 0, 0, 24'h0);
    step(3'b010, 3'b000, 1, 0, 24'h0);
    step(3'b010, 3'b000, 1, 0, 24'h0);
    tests++;
    if (alert !== 3'b010) begin fails++; $display("FAIL taken_alert got=%b want=010", alert); end
    step(3'b010, 3'b010, 0, 0, 24'h0);
    tests++;
    if (alert !== 3'b000 || count !== 3'd0) begin
      fails++;
      $display("FAIL taken_ack got alert=%b count=%0d want alert=000 count=0", alert, count);
    end
    repeat (4) step(3'b010, 3'b000, 1, 0, 24'h0);
    tests++;
    if (dut_v() !== exp_v()) begin fails++; $display("FAIL taken_quiet got=%h want=%h", dut_v(), exp_v()); end
  endtask
  task automatic test_simultaneous();
    step(3'b000, 3'b000, 0, 0, 24'h0);
    step(3'b111, 3'b000, 0, 0, 24'h0);
    step(3'b111, 3'b000, 1, 0, 24'h0);
    step(3'b111, 3'b000, 1, 0, 24'h0);
    step(3'b111, 3'b000, 1, 0, 24'h120000);
    for (int k = 1; k <= 3; k++) begin
      step(3'b111, 3'b000, 0, 0, 24'h0);
      tests++;
      if (count !== 3'(k) || dut_v() !== exp_v()) begin
        fails++;
        $display("FAIL simul_push%0d got count=%0d want=%0d (got=%h want=%h)", k, count, k, dut_v(), exp_v());
      end
    end
    for (int k = 0; k < 3; k++) begin
      tests++;
      if (rd_data !== {2'(k), 24'h120000}) begin
        fails++;
        $display("FAIL simul_order%0d got=%h want=%h", k, rd_data, {2'(k), 24'h120000});
      end
      step(3'b111, 3'b000, 0, 1, 24'h0);
    end
  endtask
  task automatic test_taken_at_expiry();
    step(3'b000, 3'b000, 0, 0, 24'h0);
    step(3'b100, 3'b000, 0, 0, 24'h0);
    step(3'b100, 3'b000, 1, 0, 24'h0);
    step(3'b100, 3'b000, 1, 0, 24'h0);
    step(3'b100, 3'b100, 1, 0, 24'h235959);
    step(3'b100, 3'b000, 0, 0, 24'h0);
    tests++;
    if (count !== 3'd0 || alert !== 3'b000 || dut_v() !== exp_v()) begin
      fails++;
      $display("FAIL taken_expiry got count=%0d alert=%b want count=0 alert=000", count, alert);
    end
  endtask
  task automatic test_overflow();
    for (int k = 1; k <= 5; k++) miss(0, 24'(k), 0);
    tests++;
    if (count !== 3'd4 || full !== 1'b1 || overflow !== 1'b1 || rd_data !== 26'd2) begin
      fails++;
      $display("FAIL overflow_state got count=%0d full=%b ovf=%b head=%h want 4 1 1 0000002", count, full, overflow, rd_data);
    end
    step(3'b000, 3'b000, 0, 1, 24'h0);
    tests++;
    if (count !== 3'd3 || overflow !== 1'b1 || dut_v() !== exp_v()) begin
      fails++;
      $display("FAIL overflow_pop got count=%0d ovf=%b want count=3 ovf=1", count, overflow);
    end
  endtask
  task automatic test_push_pop_full();
    miss(0, 24'd6, 0);
    tests++;
    if (count !== 3'd4 || full !== 1'b1) begin fails++; $display("FAIL pp_refill got count=%0d want=4", count); end
    miss(0, 24'd7, 1);
    tests++;
    if (count !== 3'd4 || overflow !== 1'b1 || dut_v() !== exp_v()) begin
      fails++;
      $display("FAIL pp_full got=%h want=%h", dut_v(), exp_v());
    end
    repeat (4) step(3'b000, 3'b000, 0, 1, 24'h0);
    step(3'b000, 3'b000, 0, 1, 24'h0);
    tests++;
    if (count !== 3'd0 || empty !== 1'b1 || rd_data !== 26'd0 || dut_v() !== exp_v()) begin
      fails++;
      $display("FAIL pop_empty got=%h want=%h", dut_v(), exp_v());
    end
  endtask
  task automatic test_reset_mid();
    step(3'b000, 3'b000, 0, 0, 24'h0);
    step(3'b001, 3'b000, 0, 0, 24'h0);
    step(3'b001, 3'b000, 1, 0, 24'h0);
    step(3'b001, 3'b000, 1, 0, 24'h0);
    tests++;
    if (alert !== 3'b001) begin fails++; $display("FAIL mid_alert got=%b want=001", alert); end
    do_reset();
    tests++;
    if (dut_v() !== {3'd0, 1'b1, 1'b0, 1'b0, 3'd0, 26'd0}) begin
      fails++;
      $display("FAIL mid_reset got=%h want=%h", dut_v(), {3'd0, 1'b1, 1'b0, 1'b0, 3'd0, 26'd0});
    end
    repeat (6) step(3'b001, 3'b000, 1, 0, 24'h0);
    tests++;
    if (count !== 3'd0 || alert !== 3'b000 || dut_v() !== exp_v()) begin
      fails++;
      $display("FAIL mid_no_edge got count=%0d alert=%b want count=0 alert=000", count, alert);
    end
  endtask
  task automatic test_random();
    logic [2:0] d = 3'b001;
    logic [2:0] tk;
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(7) == 0) d = d ^ 3'(1 << $urandom_range(2));
      tk = '0;
      for (int i = 0; i < 3; i++) tk[i] = $urandom_range(31) == 0;
      step(d, tk, $urandom_range(2) == 0, $urandom_range(4) == 0, 24'($urandom));
      tests++;
      if (dut_v() !== exp_v()) begin
        fails++;
        $display("FAIL random_c%0d got=%h want=%h", n, dut_v(), exp_v());
      end
    end
  endtask
  initial begin
    test_reset();
    test_missed();
    test_taken();
    test_simultaneous();
    test_taken_at_expiry();
    test_overflow();
    test_push_pop_full();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
